rca_seq_ctrl: RTL

- Sequencer that performs a WIDTH-bit addition by reusing a single 4-bit ripple-carry slice, one nibble per cycle, LSB nibble first.
- A registered carry links one nibble step to the next.
- Valid/ready handshake on the operand and result sides.
- Sits between operand producers and result consumers wherever a wide add is needed and area matters more than latency.

---
 rtl/rca_pkg.sv | 18 +
 rtl/adder_slice4.sv | 24 ++
 rtl/rca_seq_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/rca_pkg.sv
// Shared types and constants for the nibble-serial ripple-carry adder.
package rca_pkg;

  localparam int unsigned SLICE_W  = 4;
  localparam int unsigned SLICE_LG = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Step-index width: ceil(log2(nstep)), never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned nstep);
    return (nstep > 1) ? $clog2(nstep) : 1;
  endfunction

endpackage

// File: rtl/adder_slice4.sv
// Purely combinational 4-bit ripple-carry adder built from 1-bit full adders.
module adder_slice4
  import rca_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] s,
  output logic               cout
);

  logic [SLICE_W:0] c;

  assign c[0] = cin;

  // One full adder per bit; carry ripples upward.
  for (genvar i = 0; i < int'(SLICE_W); i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[SLICE_W];

endmodule

// File: rtl/rca_seq_ctrl.sv
// Wide adder that reuses one 4-bit slice, one nibble per cycle, LSB first.
module rca_seq_ctrl
  import rca_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int unsigned NSTEP = WIDTH / SLICE_W;
  localparam int unsigned IDX_W = idx_width(NSTEP);
  localparam int unsigned OFF_W = IDX_W + SLICE_LG;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSTEP - 1);

  // Reject widths the slice cannot tile exactly.
  if ((WIDTH < SLICE_W) || ((WIDTH % SLICE_W) != 0)) begin : g_bad_width
    $error("rca_seq_ctrl: WIDTH must be a multiple of 4 and at least 4");
  end

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             carry;
  logic [IDX_W-1:0] idx;

  logic load_c;
  logic step_c;
  logic last_c;
  logic release_c;

  logic [OFF_W-1:0]   off_c;
  logic [WIDTH-1:0]   a_sh_c;
  logic [WIDTH-1:0]   b_sh_c;
  logic [SLICE_W-1:0] slice_s_c;
  logic               slice_cout_c;
  logic [WIDTH-1:0]   sum_merged_c;

  // Bit offset of the current nibble and the operand nibbles aligned to bit 0.
  assign off_c  = {idx, {SLICE_LG{1'b0}}};
  assign a_sh_c = a_reg >> off_c;
  assign b_sh_c = b_reg >> off_c;

  adder_slice4 u_slice (
    .a    (a_sh_c[SLICE_W-1:0]),
    .b    (b_sh_c[SLICE_W-1:0]),
    .cin  (carry),
    .s    (slice_s_c),
    .cout (slice_cout_c)
  );

  // Replace only the nibble being computed; other bits keep their old value.
  assign sum_merged_c = (sum & ~(WIDTH'({SLICE_W{1'b1}}) << off_c))
                      | (WIDTH'(slice_s_c) << off_c);

  assign in_ready = (state == IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and per-cycle control strobes.
  always_comb begin
    state_nxt = state;
    load_c    = 1'b0;
    step_c    = 1'b0;
    last_c    = 1'b0;
    release_c = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          load_c    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        step_c = 1'b1;
        if (idx == LAST_IDX) begin
          last_c    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          release_c = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture on the accept handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg <= '0;
      b_reg <= '0;
    end else if (load_c) begin
      a_reg <= a;
      b_reg <= b;
    end
  end

  // Step index and inter-nibble carry; index holds at the last step.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx   <= '0;
      carry <= 1'b0;
    end else if (load_c) begin
      idx   <= '0;
      carry <= cin;
    end else if (step_c) begin
      carry <= slice_cout_c;
      if (!last_c) begin
        idx <= idx + IDX_W'(1);
      end
    end
  end

  // Registered result, carry-out, valid and busy flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum       <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      busy <= (state_nxt != IDLE);
      if (step_c) begin
        sum <= sum_merged_c;
      end
      if (last_c) begin
        cout      <= slice_cout_c;
        out_valid <= 1'b1;
      end else if (release_c) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
